lut_neuron_layer: RTL and testbench
===================================

LUT_NEURON_LAYER -- requirements
Module: lut_neuron_layer

Interface
REQ-001 SHALL have parameter IN_BITS, default 8, meaning input bits per neuron (table depth 2^IN_BITS).
REQ-002 SHALL have parameter OUT_BITS, default 1, meaning output bits per neuron (table entry width).
REQ-003 SHALL have parameter NUM_NEURONS, default 4, meaning neurons evaluated in parallel per transaction.
REQ-004 SHALL have port: clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: cfg_we  input  1  table write strobe.
REQ-007 SHALL have port: cfg_neuron  input  max(1,clog2(NUM_NEURONS))  target neuron index.
REQ-008 SHALL have port: cfg_addr  input  IN_BITS  table entry address.
REQ-009 SHALL have port: cfg_data  input  OUT_BITS  table entry value.
REQ-010 SHALL have port: cfg_done  input  1  one-cycle pulse ending initial load.
REQ-011 SHALL have port: in_valid / in_ready  input / output  1 each  input handshake.
REQ-012 SHALL have port: in_data  input  NUM_NEURONS*IN_BITS  neuron n uses slice [n*IN_BITS +: IN_BITS].
REQ-013 SHALL have port: out_valid / out_ready  output / input  1 each  output handshake.
REQ-014 SHALL have port: out_data  output  NUM_NEURONS*OUT_BITS  neuron n result in slice [n*OUT_BITS +: OUT_BITS].
REQ-015 SHALL have port: lookups  output  16  count of accepted input transactions.

Function
REQ-016 SHALL implement two states, LOAD and RUN; LOAD -> RUN on cfg_done; RUN has no exit except reset.
REQ-017 SHALL hold in_ready low in LOAD; in RUN, in_ready = !out_valid || out_ready.
REQ-018 SHALL write cfg_data into table[cfg_neuron][cfg_addr] on any cycle with cfg_we high, in either state; cfg_neuron >= NUM_NEURONS ignored.
REQ-019 SHALL, on in_valid && in_ready, register out_data[n] = table[n][in_data slice n] and set out_valid next cycle (latency 1).
REQ-020 SHALL clear out_valid on out_valid && out_ready with no simultaneous acceptance; simultaneous accept and drain keeps out_valid high with new data (full throughput).
REQ-021 SHALL hold out_data stable while out_valid && !out_ready.
REQ-022 SHALL return the pre-write value when a write and a lookup hit the same entry in the same cycle.
REQ-023 SHALL increment lookups per accepted transaction, saturating at 16'hFFFF.
REQ-024 SHALL treat cfg_done in RUN as no-op; cfg_done coincident with cfg_we applies the write and transitions.

Reset
REQ-025 SHALL on rst_n low force state LOAD, out_valid 0, out_data 0, lookups 0, in_ready 0, asynchronously.
REQ-026 SHALL NOT reset table contents; reset mid-transaction discards the pending output.

Configuration
REQ-027 SHALL, with LUT_LAYER_PARITY_EN defined, store an even-parity bit per entry, check it on every lookup, and drive extra output perr (1 bit) sticky-high on any mismatch until reset.
REQ-028 SHALL, without LUT_LAYER_PARITY_EN, omit parity storage and the perr port entirely.

Structure
REQ-029 SHALL place the state enum (LOAD, RUN) and the cfg_neuron width helper function in package lut_layer_pkg.
REQ-030 SHALL instantiate one sub-module lut_neuron_ram per neuron: synchronous write port, combinational read, distributed-RAM style.

Verification
REQ-031 Reset, then in_valid=1 in LOAD -> in_ready=0, out_valid=0, lookups=0.
REQ-032 Load neuron 0 table[8'hA0]=1 (defaults IN_BITS=8, OUT_BITS=1, NUM_NEURONS=4), others 0, cfg_done, send in_data slice0=8'hA0 -> out_data=4'b0001 one cycle later, lookups=1.
REQ-033 Hold out_ready=0 for 5 cycles with in_valid=1 -> out_data unchanged, in_ready=0, lookups stays 1; release -> next beat accepted same cycle.
REQ-034 Streaming 100 beats with out_ready=1 -> 100 outputs back-to-back, lookups=100.
REQ-035 Write table[1][8'h05]=1 in same cycle as lookup of neuron 1 address 8'h05 (old value 0) -> output bit1=0; repeat lookup -> bit1=1.
REQ-036 With LUT_LAYER_PARITY_EN, force-flip one stored data bit, look it up -> perr=1 and stays 1 until rst_n low.

Source files
------------

// File: rtl/lut_layer_pkg.sv
// rtl/lut_layer_pkg.sv - shared state encoding and sizing helper for the LUT neuron layer
package lut_layer_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A single-neuron layer still needs a one-bit select port.
  function automatic int neuron_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// rtl/lut_neuron_ram.sv - one neuron truth table: synchronous write, combinational read
module lut_neuron_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately never reset so a table survives a layer reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_layer.sv
// rtl/lut_neuron_layer.sv - parallel LUT neurons with load/run phases; LUT_LAYER_PARITY_EN adds per-entry parity and perr
module lut_neuron_layer
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_we,
  input  logic [neuron_idx_w(NUM_NEURONS)-1:0] cfg_neuron,
  input  logic [IN_BITS-1:0]                   cfg_addr,
  input  logic [OUT_BITS-1:0]                  cfg_data,
  input  logic                                 cfg_done,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]       in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0]      out_data,
`ifdef LUT_LAYER_PARITY_EN
  output logic                                 perr,
`endif
  output logic [15:0]                          lookups
);

  localparam int NW = neuron_idx_w(NUM_NEURONS);
`ifdef LUT_LAYER_PARITY_EN
  localparam int ENTRY_W = OUT_BITS + 1;
`else
  localparam int ENTRY_W = OUT_BITS;
`endif

  state_t                        state;
  logic                          accept;
  logic [ENTRY_W-1:0]            entry_wdata;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup_data;
`ifdef LUT_LAYER_PARITY_EN
  logic [NUM_NEURONS-1:0]        parity_miss;

  // Even parity: stored parity bit plus data must contain an even number of ones.
  assign entry_wdata = {^cfg_data, cfg_data};
`else
  assign entry_wdata = cfg_data;
`endif

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic               we_n;
    logic [ENTRY_W-1:0] rdata;

    assign we_n = cfg_we && (cfg_neuron == NW'(n));

    lut_neuron_ram #(
      .ADDR_W(IN_BITS),
      .DATA_W(ENTRY_W)
    ) u_ram (
      .clk  (clk),
      .we   (we_n),
      .waddr(cfg_addr),
      .wdata(entry_wdata),
      .raddr(in_data[n*IN_BITS +: IN_BITS]),
      .rdata(rdata)
    );

    assign lookup_data[n*OUT_BITS +: OUT_BITS] = rdata[OUT_BITS-1:0];
`ifdef LUT_LAYER_PARITY_EN
    assign parity_miss[n] = ^rdata;
`endif
  end

  // Read is combinational, so a same-cycle write lands after the old value is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      out_valid <= 1'b0;
      out_data  <= '0;
      lookups   <= '0;
    end else begin
      if (state == ST_LOAD && cfg_done) begin
        state <= ST_RUN;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= lookup_data;
        if (lookups != 16'hFFFF) begin
          lookups <= lookups + 16'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LUT_LAYER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= 1'b0;
    end else if (accept && |parity_miss) begin
      perr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_neuron_layer.sv
// tb/tb_lut_neuron_layer.sv - bench for lut_neuron_layer; LUT_LAYER_PARITY_EN enables the perr scenario
module tb_lut_neuron_layer;

  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [7:0]  cfg_addr;
  logic [0:0]  cfg_data;
  logic        cfg_done;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [15:0] lookups;
`ifdef LUT_LAYER_PARITY_EN
  logic        perr;
`endif

  always #5 clk = ~clk;

  lut_neuron_layer #(
    .IN_BITS(8),
    .OUT_BITS(1),
    .NUM_NEURONS(NN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef LUT_LAYER_PARITY_EN
    .perr      (perr),
`endif
    .lookups   (lookups)
  );

  int         errors = 0;
  int         checks = 0;
  bit         model_tbl [NN][256];
  logic [3:0] exp_q [$];
  int         model_count = 0;
  bit         model_run = 1'b0;
  bit         exp_ready;
  int         nout;
  int         base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_lookup(input logic [31:0] d);
    logic [3:0] r;
    for (int n = 0; n < NN; n++) r[n] = model_tbl[n][d[n*8 +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: a one-deep output slot fed from a table snapshot taken before writes.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_count = 0;
      model_run   = 1'b0;
    end else begin
      check("mon_out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) check("mon_out_data", out_data, exp_q[0]);
      exp_ready = model_run && (exp_q.size() == 0 || out_ready);
      check("mon_in_ready", in_ready, exp_ready);
      check("mon_lookups", lookups, model_count);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) begin
        exp_q.push_back(model_lookup(in_data));
        if (model_count < 65535) model_count++;
      end
      if (cfg_we && int'(cfg_neuron) < NN) model_tbl[cfg_neuron][cfg_addr] = cfg_data[0];
      if (cfg_done) model_run = 1'b1;
    end
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_done = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_lookups", lookups, 0);
    rst_n = 1'b1;
    tick();
    check("load_in_ready", in_ready, 0);

    // Fill every table; the final write carries cfg_done as well.
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < 256; a++) begin
        cfg_we = 1'b1; cfg_neuron = 2'(n); cfg_addr = 8'(a);
        cfg_data = (n == 0 && a == 8'hA0) ? 1'b1 : 1'b0;
        if (n == NN - 1 && a == 255) begin
          cfg_done = 1'b1;
          in_valid = 1'b0;
        end
        tick();
      end
    end
    cfg_we = 1'b0; cfg_done = 1'b0;
    check("run_in_ready", in_ready, 1);
    check("run_lookups", lookups, 0);

    in_valid = 1'b1; in_data = 32'h000000A0;
    tick();
    in_valid = 1'b0;
    check("first_out_valid", out_valid, 1);
    check("first_out_data", out_data, 4'b0001);
    check("first_lookups", lookups, 1);

    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h00000011;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_data", out_data, 4'b0001);
      check("stall_in_ready", in_ready, 0);
      check("stall_lookups", lookups, 1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("release_out_data", out_data, 4'b0000);
    check("release_lookups", lookups, 2);
    tick();
    check("drain_out_valid", out_valid, 0);

    cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 8'h05; cfg_data = 1'b1;
    in_valid = 1'b1; in_data = 32'h00000500;
    tick();
    cfg_we = 1'b0;
    check("rdw_old_value", out_data, 4'b0000);
    tick();
    in_valid = 1'b0;
    check("rdw_new_value", out_data, 4'b0010);
    tick();

    for (int i = 0; i < 300; i++) begin
      cfg_we = 1'($urandom); cfg_neuron = 2'($urandom); cfg_addr = 8'($urandom); cfg_data = 1'($urandom);
      in_valid = 1'($urandom); in_data = $urandom; out_ready = ($urandom_range(3) != 0);
      tick();
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    check("drain_bound", out_valid, 0);

    base = model_count; nout = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = $urandom;
      tick();
      if (out_valid) nout++;
    end
    in_valid = 1'b0;
    check("stream_beats", nout, 100);
    check("stream_lookups", lookups, base + 100);
    tick();

    in_valid = 1'b1; in_data = 32'h000000A0;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 0);
    check("async_lookups", lookups, 0);
    check("async_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    check("reload_in_ready", in_ready, 0);
    cfg_done = 1'b1;
    tick();
    check("rerun_in_ready", in_ready, 1);
    tick();
    cfg_done = 1'b0;
    check("done_in_run_noop", in_ready, 1);
    in_valid = 1'b1; in_data = 32'h000000A0;
    tick();
    in_valid = 1'b0;
    check("retained_lookups", lookups, 1);
    tick();

`ifdef LUT_LAYER_PARITY_EN
    check("perr_clear", perr, 0);
    cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 8'h33; cfg_data = 1'b1;
    tick();
    cfg_we = 1'b0;
    dut.g_neuron[0].u_ram.mem[8'h33] = 2'b10;
    model_tbl[0][8'h33] = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000033;
    tick();
    in_valid = 1'b0;
    check("perr_set", perr, 1);
    repeat (3) tick();
    check("perr_sticky", perr, 1);
    rst_n = 1'b0;
    #1;
    check("perr_reset", perr, 0);
    tick();
    rst_n = 1'b1;
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
